seq_alu: RTL

- Parametrised multi-cycle ALU, next generation of the datapath's single-cycle ALU.
- Keeps the same single-cycle logic/arithmetic ops and opcode encoding, generalised to WIDTH bits.
- Adds a true unsigned multiply (full 2*WIDTH product) and unsigned divide, both iterative, plus a start/busy/done handshake.
- Sits beside the main ALU in the execute stage; the control unit stalls the pipeline while busy is high.

---
 rtl/seq_alu_pkg.sv | 19 +
 rtl/seq_alu_iter.sv | 66 ++++++
 rtl/seq_alu.sv | 108 ++++++++++
 3 files changed

// File: rtl/seq_alu_pkg.sv
// Shared opcode and state encodings for the multi-cycle ALU.
package seq_alu_pkg;
    localparam logic [3:0] AND  = 4'd0;
    localparam logic [3:0] OR   = 4'd1;
    localparam logic [3:0] NOR  = 4'd2;
    localparam logic [3:0] ADD  = 4'd3;
    localparam logic [3:0] SUB  = 4'd4;
    localparam logic [3:0] MULT = 4'd5;
    localparam logic [3:0] DIVU = 4'd6;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] MUL  = 2'd1;
    localparam logic [1:0] DIV  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    function automatic logic is_legal_op(input logic [3:0] op);
        return op <= DIVU;
    endfunction
endpackage

// File: rtl/seq_alu_iter.sv
// Shared shift/accumulate datapath: shift-add multiply or restoring divide,
// one bit per step. lo_next/hi_next expose the post-step value so the final
// step can be captured directly into the output registers.
module seq_alu_iter
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
    input  logic             mode_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             last,
    output logic [WIDTH-1:0] lo_next,
    output logic [WIDTH-1:0] hi_next
);
    logic [WIDTH-1:0] acc, q, d;
    logic [CNT_W-1:0] cnt;
    logic             div_r;
    logic [WIDTH:0]   mul_sum, shifted, diff;

    always_comb begin
        mul_sum = {1'b0, acc} + {1'b0, (q[0] ? d : {WIDTH{1'b0}})};
        shifted = {acc, q[WIDTH-1]};
        diff    = shifted - {1'b0, d};
        if (div_r) begin
            // acc < d always holds, so diff's MSB is a clean borrow flag
            if (!diff[WIDTH]) begin
                hi_next = diff[WIDTH-1:0];
                lo_next = {q[WIDTH-2:0], 1'b1};
            end else begin
                hi_next = shifted[WIDTH-1:0];
                lo_next = {q[WIDTH-2:0], 1'b0};
            end
        end else begin
            hi_next = mul_sum[WIDTH:1];
            lo_next = {mul_sum[0], q[WIDTH-1:1]};
        end
    end

    assign last = (cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc   <= '0;
            q     <= '0;
            d     <= '0;
            cnt   <= '0;
            div_r <= 1'b0;
        end else if (load) begin
            acc   <= '0;
            q     <= mode_div ? a : b;
            d     <= mode_div ? b : a;
            cnt   <= '0;
            div_r <= mode_div;
        end else if (step) begin
            acc <= hi_next;
            q   <= lo_next;
            cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/seq_alu.sv
// Multi-cycle ALU: single-cycle logic/arith ops plus iterative unsigned
// multiply and divide behind a start/busy/done handshake.
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       alu_op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic             zero,
    output logic             illegal_op
);
    logic [1:0]       state;
    logic [WIDTH-1:0] alu_res, lo_next, hi_next;
    logic             accept, b_zero, iter_load, last;

    assign accept    = start && (state == IDLE);
    assign b_zero    = (b == '0);
    assign iter_load = accept && ((alu_op == MULT) || (alu_op == DIVU && !b_zero));
    assign busy      = (state == MUL) || (state == DIV);
    assign done      = (state == DONE);

    always_comb begin
        alu_res = '0;
        case (alu_op)
            AND:     alu_res = a & b;
            OR:      alu_res = a | b;
            NOR:     alu_res = ~(a | b);
            ADD:     alu_res = a + b;
            SUB:     alu_res = a - b;
            default: alu_res = '0;
        endcase
    end

    seq_alu_iter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_iter (
        .clk      (clk),
        .reset    (reset),
        .load     (iter_load),
        .step     (busy),
        .mode_div (alu_op == DIVU),
        .a        (a),
        .b        (b),
        .last     (last),
        .lo_next  (lo_next),
        .hi_next  (hi_next)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            result_lo  <= '0;
            result_hi  <= '0;
            zero       <= 1'b0;
            illegal_op <= 1'b0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    illegal_op <= 1'b0;
                    if (!is_legal_op(alu_op)) begin
                        result_lo  <= '0;
                        result_hi  <= '0;
                        zero       <= 1'b1;
                        illegal_op <= 1'b1;
                        state      <= DONE;
                    end else if (alu_op == MULT) begin
                        state <= MUL;
                    end else if (alu_op == DIVU) begin
                        if (b_zero) begin
                            result_lo <= '1;
                            result_hi <= a;
                            zero      <= 1'b0;
                            state     <= DONE;
                        end else begin
                            state <= DIV;
                        end
                    end else begin
                        result_lo <= alu_res;
                        result_hi <= '0;
                        zero      <= (alu_res == '0);
                        state     <= DONE;
                    end
                end
                MUL: if (last) begin
                    result_lo <= lo_next;
                    result_hi <= hi_next;
                    zero      <= ({hi_next, lo_next} == '0);
                    state     <= DONE;
                end
                DIV: if (last) begin
                    result_lo <= lo_next;
                    result_hi <= hi_next;
                    zero      <= (lo_next == '0);
                    state     <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
